// File: rtl/dbg_frame_tx_pkg.sv
// Shared constants for the debug snapshot framer.
// Default snapshot width is built from the pipeline latch widths.
package dbg_frame_tx_pkg;

  localparam int DBG_NB_DATA = 8;
  localparam logic [7:0] DBG_HEADER = 8'hA5;

  localparam int ID_EX_W  = 128;
  localparam int EX_MEM_W = 72;
  localparam int MEM_WB_W = 40;
  localparam int WB_ID_W  = 40;
  localparam int CTRL_W   = 8;

  localparam int DBG_NB_SNAPSHOT =
    ID_EX_W + EX_MEM_W + MEM_WB_W +
    WB_ID_W + CTRL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dbg_frame_tx.sv
// Serialises a pipeline snapshot into a framed byte stream
// for uart_tx: header, payload LSB-first, XOR checksum.
module dbg_frame_tx
  import dbg_frame_tx_pkg::*;
#(
  parameter int NB_DATA     = DBG_NB_DATA,
  parameter int NB_SNAPSHOT = DBG_NB_SNAPSHOT,
  parameter logic [NB_DATA-1:0] HEADER =
    NB_DATA'(DBG_HEADER)
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [NB_SNAPSHOT-1:0] i_snapshot,
  input  logic                   i_txDone,
  output logic                   o_tx_start,
  output logic [NB_DATA-1:0]     o_data,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int N  = NB_SNAPSHOT / NB_DATA;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST_PAY = CW'(N);
  localparam logic [CW-1:0] LAST     = CW'(N + 1);

  if (NB_SNAPSHOT % NB_DATA != 0) begin : g_bad_width
    $error("NB_SNAPSHOT must be a multiple of NB_DATA");
  end

  state_e                 state_q;
  logic [NB_SNAPSHOT-1:0] shift_q;
  logic [NB_DATA-1:0]     csum_q;
  logic [CW-1:0]          cnt_q;
  logic                   tx_start_q;
  logic [NB_DATA-1:0]     data_q;
  logic                   busy_q;
  logic                   done_q;

  // cnt_q is the index of the byte currently on the line
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            shift_q    <= i_snapshot;
            csum_q     <= HEADER;
            cnt_q      <= '0;
            data_q     <= HEADER;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_txDone) begin
            if (cnt_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              tx_start_q <= 1'b1;
              state_q    <= S_SEND;
              if (cnt_q == LAST_PAY) begin
                data_q <= csum_q;
              end else begin
                data_q  <= shift_q[NB_DATA-1:0];
                csum_q  <= csum_q ^ shift_q[NB_DATA-1:0];
                shift_q <= shift_q >> NB_DATA;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_data     = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_dbg_frame_tx.sv
// Directed bench for dbg_frame_tx with a 32-bit snapshot
// and a uart_tx model answering 10 cycles after each start.
module tb_dbg_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] snap;
  logic        txdone;
  logic        tx_start;
  logic [7:0]  data;
  logic        busy;
  logic        done;

  logic model_done = 1'b0;
  logic spur;
  int   dly = 0;

  logic [7:0] got[$];
  int   done_cnt = 0;
  int   stab_err = 0;
  logic [7:0] held = 8'h00;
  bit   in_byte = 0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign txdone = model_done | spur;

  dbg_frame_tx #(
    .NB_SNAPSHOT(32)
  ) dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_snapshot(snap),
    .i_txDone  (txdone),
    .o_tx_start(tx_start),
    .o_data    (data),
    .o_busy    (busy),
    .o_done    (done)
  );

  // uart_tx model
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) begin
      dly = 0;
    end else begin
      if (dly > 0) begin
        dly = dly - 1;
        if (dly == 0) model_done = 1'b1;
      end
      if (tx_start) dly = 10;
    end
  end

  // byte / done recorder and o_data hold watcher
  always @(negedge clk) begin
    if (!rst_n) begin
      in_byte = 0;
    end else begin
      if (tx_start) begin
        got.push_back(data);
        held    = data;
        in_byte = 1;
      end else if (in_byte && data !== held) begin
        stab_err = stab_err + 1;
      end
      if (txdone) in_byte = 0;
      if (done) done_cnt = done_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [31:0] s);
    @(negedge clk);
    snap  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_tx_start", 64'(tx_start), 64'd1);
    chk("lat_header", 64'(data), 64'hA5);
    chk("lat_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic check_frame(input string tag,
                             input logic [47:0] e,
                             input int base,
                             input int ndone);
    logic [7:0] ob;
    wait_done({tag, "_done_seen"});
    @(negedge clk);
    chk({tag, "_nbytes"}, 64'(got.size()), 64'(base + 6));
    for (int i = 0; i < 6; i++) begin
      ob = (base + i < got.size()) ? got[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i),
          64'(ob), 64'(e[8*i +: 8]));
    end
    chk({tag, "_ndone"}, 64'(done_cnt), 64'(ndone));
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic clear_log();
    got.delete();
    done_cnt = 0;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    spur  = 1'b0;
    snap  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame
    clear_log();
    start_frame(32'h12345678);
    repeat (5) @(negedge clk);
    chk("f1_hold", 64'(data), 64'hA5);
    check_frame("f1", {8'hAD, 8'h12, 8'h34, 8'h56,
                       8'h78, 8'hA5}, 0, 1);

    // all-zero payload
    clear_log();
    start_frame(32'h0);
    check_frame("f0", {8'hA5, 8'h00, 8'h00, 8'h00,
                       8'h00, 8'hA5}, 0, 1);

    // restart and snapshot change mid-frame
    clear_log();
    start_frame(32'h12345678);
    repeat (15) @(negedge clk);
    snap  = 32'hFFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_frame("f_ign", {8'hAD, 8'h12, 8'h34, 8'h56,
                          8'h78, 8'hA5}, 0, 1);
    repeat (30) @(negedge clk);
    chk("f_ign_no_second", 64'(got.size()), 64'd6);
    chk("f_ign_idle", 64'(busy), 64'd0);

    // spurious txDone in IDLE
    clear_log();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (5) @(negedge clk);
    chk("spur_idle_busy", 64'(busy), 64'd0);
    chk("spur_idle_bytes", 64'(got.size()), 64'd0);

    // spurious txDone in SEND
    @(negedge clk);
    snap  = 32'hA1B2C3D4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spur  = 1'b1;
    @(negedge clk);
    spur  = 1'b0;
    chk("spur_send_busy", 64'(busy), 64'd1);
    chk("spur_send_nbytes", 64'(got.size()), 64'd1);
    check_frame("f_spur", {8'hA1, 8'hA1, 8'hB2, 8'hC3,
                           8'hD4, 8'hA5}, 0, 1);

    // reset after third byte
    clear_log();
    start_frame(32'hCAFEF00D);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (got.size() >= 3) seen = 1;
    end
    chk("abort_reach3", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_tx_start", 64'(tx_start), 64'd0);
    chk("abort_data", 64'(data), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_nbytes", 64'(got.size()), 64'd3);
    chk("abort_ndone", 64'(done_cnt), 64'd0);
    clear_log();
    start_frame(32'hDEADBEEF);
    check_frame("f_dead", {8'h87, 8'hDE, 8'hAD, 8'hBE,
                           8'hEF, 8'hA5}, 0, 1);

    // back-to-back, start held through DONE
    clear_log();
    start_frame(32'h12345678);
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("b2b_first_done", 64'(seen), 64'd1);
    snap  = 32'h0;
    start = 1'b1;
    @(negedge clk);
    chk("b2b_done_ign_tx", 64'(tx_start), 64'd0);
    chk("b2b_done_ign_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_tx_start", 64'(tx_start), 64'd1);
    chk("b2b_header", 64'(data), 64'hA5);
    check_frame("b2b", {8'hA5, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'hA5}, 6, 2);

    chk("data_hold", 64'(stab_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_frame_tx.md
DBG_FRAME_TX -- requirements
Module: dbg_frame_tx

Interface
REQ-001 Parameter NB_DATA, default 8, UART byte width.
REQ-002 Parameter NB_SNAPSHOT, default 288, snapshot width in bits; SHALL be a multiple of NB_DATA (elaboration error otherwise).
REQ-003 Parameter HEADER, default 8'hA5, frame start byte.
REQ-004 Port clk  input  1  single system clock, rising edge.
REQ-005 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 Port i_start  input  1  request to send one snapshot frame.
REQ-007 Port i_snapshot  input  NB_SNAPSHOT  pipeline debug state (latches, registers, control) to dump.
REQ-008 Port i_txDone  input  1  one-cycle pulse from uart_tx when the current byte has left the line.
REQ-009 Port o_tx_start  output  1  one-cycle pulse starting uart_tx on o_data.
REQ-010 Port o_data  output  NB_DATA  byte presented to uart_tx.
REQ-011 Port o_busy  output  1  high while a frame is in progress.
REQ-012 Port o_done  output  1  one-cycle pulse after the checksum byte completes.

Function
REQ-013 Frame = HEADER, then NB_SNAPSHOT/NB_DATA payload bytes least-significant byte first, then one checksum byte.
REQ-014 Checksum = XOR of HEADER and all payload bytes.
REQ-015 FSM states: IDLE, SEND, WAIT, DONE.
REQ-016 IDLE: i_start high -> i_snapshot captured into an internal shift register, checksum reg := HEADER, byte counter := 0, next state SEND.
REQ-017 Snapshot captured only on the accepting cycle; later i_snapshot changes do not affect the frame.
REQ-018 SEND: o_data driven with the current byte and o_tx_start high for exactly one cycle, next state WAIT.
REQ-019 Byte order per SEND: index 0 = HEADER, indices 1..N = payload (shift register shifted right NB_DATA bits per payload byte, checksum XOR-accumulated), index N+1 = checksum reg.
REQ-020 o_data held stable from the SEND cycle until the matching i_txDone.
REQ-021 WAIT: on i_txDone, counter increments; counter < N+1 -> SEND; counter = N+1 -> DONE.
REQ-022 DONE: o_done high one cycle, next state IDLE.
REQ-023 Per-byte latency: o_tx_start asserts one cycle after acceptance or one cycle after the previous i_txDone.
REQ-024 o_busy high in SEND, WAIT and DONE; low in IDLE.
REQ-025 i_start while o_busy is high is ignored (not queued).
REQ-026 i_txDone outside WAIT is ignored.
REQ-027 i_start in the DONE cycle is ignored; a new frame may be accepted from the next IDLE cycle.
REQ-028 Counter width = clog2(N+2) bits; no wrap-around within a frame.

Reset
REQ-029 i_rst_n low asynchronously forces IDLE, o_tx_start=0, o_data=0, o_busy=0, o_done=0, counter=0, shift and checksum regs=0.
REQ-030 Reset mid-frame aborts the frame; no further bytes are emitted; no o_done is produced.
REQ-031 After deassertion, first i_start is accepted normally.

Structure
REQ-032 Shared package holds NB_DATA, HEADER, the FSM state encoding (2 bits) and the default snapshot width composed from the pipeline latch widths (ID_EX, EX_MEM, MEM_WB, WB_ID, control).
REQ-033 Single module, no sub-modules; sits between the uart_interface dump request and uart_tx.

Verification (bench overrides NB_SNAPSHOT=32; uart_tx model returns i_txDone 10 cycles after o_tx_start)
REQ-034 i_snapshot=32'h12345678, i_start pulse -> bytes A5,78,56,34,12,AD, five o_tx_start pulses plus one for checksum, single o_done.
REQ-035 i_snapshot=0 -> A5,00,00,00,00,A5.
REQ-036 i_start re-pulsed and i_snapshot changed during the frame -> frame unchanged, no second frame.
REQ-037 Spurious i_txDone in IDLE and in SEND -> no state change, no extra byte.
REQ-038 i_rst_n low after the third byte -> all outputs 0 immediately, no o_done; new i_start with 32'hDEADBEEF -> A5,EF,BE,AD,DE,checksum 8'hA5^8'hEF^8'hBE^8'hAD^8'hDE.
REQ-039 Back-to-back: i_start asserted in the cycle after o_done -> second frame begins with o_tx_start one cycle later.
